// File: rtl/tpm_tis_pkg.sv
// Shared types and constants for the TPM TIS locality-0 controller:
// state encoding, register offsets and ACCESS/STS bit positions.
package tpm_tis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_RECEPTION,
    ST_EXEC_CMD,
    ST_EXEC_RSP,
    ST_COMPLETION
  } tis_state_e;

  localparam logic [15:0] REG_ACCESS    = 16'h0000;
  localparam logic [15:0] REG_STS       = 16'h0018;
  localparam logic [15:0] REG_DATA_FIFO = 16'h0024;
  localparam logic [15:0] REG_DID_VID   = 16'h0F00;
  localparam logic [15:0] REG_RID       = 16'h0F04;

  localparam int ACC_REQUEST_USE = 1;
  localparam int ACC_ACTIVE      = 5;
  localparam int ACC_REG_VALID   = 7;

  localparam int STS_EXPECT      = 3;
  localparam int STS_DATA_AVAIL  = 4;
  localparam int STS_GO          = 5;
  localparam int STS_CMD_READY   = 6;
  localparam int STS_VALID       = 7;

  // Command header: tag(2) + big-endian size(4); size is known once this many bytes are in.
  localparam int CMD_HDR_LEN = 6;

  function automatic logic same_dword(input logic [15:0] a, input logic [15:0] b);
    return a[15:2] == b[15:2];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus single-cycle
// rise/fall pulses derived from the synchronised value.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/tpm_tis_ctrl.sv
// TPM TIS locality-0 register/FIFO controller: SPI-side byte handshakes,
// command/response buffer and the TIS command state machine.
module tpm_tis_ctrl
  import tpm_tis_pkg::*;
#(
  parameter int          BUF_DEPTH = 64,
  parameter logic [31:0] DID_VID   = 32'h0001_1AF4,
  parameter logic [7:0]  RID       = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_cs_i,
  input  logic [15:0] spi_addr_i,
  input  logic [7:0]  spi_data_i,
  input  logic        spi_wr_i,
  output logic        spi_wr_done_o,
  input  logic        spi_req_i,
  output logic [7:0]  spi_data_o,
  output logic        spi_rd_o,
  output logic [7:0]  cmd_data_o,
  output logic        cmd_valid_o,
  output logic        cmd_last_o,
  input  logic        cmd_ready_i,
  input  logic [7:0]  rsp_data_i,
  input  logic        rsp_valid_i,
  input  logic        rsp_last_i,
  output logic        rsp_ready_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(BUF_DEPTH);

  logic cs_level, cs_rise_unused, cs_fall_unused;
  logic wr_rise, wr_level_unused, wr_fall_unused;
  logic req_rise, req_fall, req_level_unused;

  sync_edge u_cs_sync (.clk(clk_i), .rst_n(rst_n_i), .async_in(spi_cs_i),
                       .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall_unused));
  sync_edge u_wr_sync (.clk(clk_i), .rst_n(rst_n_i), .async_in(spi_wr_i),
                       .level(wr_level_unused), .rise(wr_rise), .fall(wr_fall_unused));
  sync_edge u_req_sync (.clk(clk_i), .rst_n(rst_n_i), .async_in(spi_req_i),
                        .level(req_level_unused), .rise(req_rise), .fall(req_fall));

  tis_state_e  state, state_next;
  logic        active;
  ptr_t        wr_ptr, rd_ptr, rsp_len;
  logic [31:0] cmd_size;
  logic [15:0] offset, eff_addr;
  logic [7:0]  mem [BUF_DEPTH];

  assign eff_addr = spi_addr_i + offset;

  logic hit_access, hit_sts, hit_fifo, hit_did, hit_rid;
  assign hit_access = eff_addr == REG_ACCESS;
  assign hit_sts    = same_dword(eff_addr, REG_STS);
  assign hit_fifo   = same_dword(eff_addr, REG_DATA_FIFO);
  assign hit_did    = same_dword(eff_addr, REG_DID_VID);
  assign hit_rid    = eff_addr == REG_RID;

  // A write edge always wins over a coincident req edge.
  logic rd_fetch, rd_consume, sts_wr, cmd_ready_wr, go_wr, fifo_wr;
  assign rd_fetch     = req_rise & ~wr_rise;
  assign rd_consume   = req_fall & ~wr_rise;
  assign sts_wr       = wr_rise & active & (eff_addr == REG_STS);
  assign cmd_ready_wr = sts_wr & spi_data_i[STS_CMD_READY];
  assign go_wr        = sts_wr & spi_data_i[STS_GO] & ~spi_data_i[STS_CMD_READY];
  assign fifo_wr      = wr_rise & active & hit_fifo;

  logic expect_bit, data_avail, buf_full, oversize;
  assign expect_bit = (state == ST_RECEPTION) &&
                      ((wr_ptr < ptr_t'(CMD_HDR_LEN)) || (32'(wr_ptr) < cmd_size));
  assign data_avail = (state == ST_COMPLETION) && (rd_ptr < rsp_len);
  assign buf_full   = wr_ptr == DEPTH_P;
  assign oversize   = cmd_size > 32'(BUF_DEPTH);

  logic [15:0] burst_count;
  logic [7:0]  sts_byte0, rd_value;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    burst_count = '0;
    case (state)
      ST_READY, ST_RECEPTION: burst_count = 16'(DEPTH_P - wr_ptr);
      ST_COMPLETION:          burst_count = 16'(rsp_len - rd_ptr);
      default:                burst_count = '0;
    endcase
  end

  always_comb begin
    sts_byte0                 = '0;
    sts_byte0[STS_VALID]      = 1'b1;
    sts_byte0[STS_CMD_READY]  = state == ST_READY;
    sts_byte0[STS_DATA_AVAIL] = data_avail;
    sts_byte0[STS_EXPECT]     = expect_bit;

    rd_value = 8'hFF;
    if (hit_access) begin
      rd_value                = '0;
      rd_value[ACC_REG_VALID] = 1'b1;
      rd_value[ACC_ACTIVE]    = active;
    end else if (hit_sts) begin
      case (eff_addr[1:0])
        2'd0:    rd_value = sts_byte0;
        2'd1:    rd_value = burst_count[7:0];
        2'd2:    rd_value = burst_count[15:8];
        default: rd_value = 8'h00;
      endcase
    end else if (hit_fifo) begin
      rd_value = (active && data_avail) ? mem[rd_ptr[IDX_W-1:0]] : 8'hFF;
    end else if (hit_did) begin
      rd_value = DID_VID[{eff_addr[1:0], 3'b000} +: 8];
    end else if (hit_rid) begin
      rd_value = RID;
    end
  end

  logic ptr_clear, fifo_store, cmd_adv, rsp_store, rd_adv, rd_clear;

  always_comb begin
    state_next  = state;
    ptr_clear   = 1'b0;
    fifo_store  = 1'b0;
    cmd_adv     = 1'b0;
    rsp_store   = 1'b0;
    rd_adv      = 1'b0;
    rd_clear    = 1'b0;
    cmd_valid_o = 1'b0;
    rsp_ready_o = 1'b0;
    case (state)
      ST_IDLE: if (cmd_ready_wr) begin
        state_next = ST_READY;
        ptr_clear  = 1'b1;
      end
      ST_READY: begin
        if (cmd_ready_wr) ptr_clear = 1'b1;
        else if (fifo_wr) begin
          state_next = ST_RECEPTION;
          fifo_store = 1'b1;
        end
      end
      ST_RECEPTION: begin
        if (cmd_ready_wr) begin
          state_next = ST_READY;
          ptr_clear  = 1'b1;
        end else if (fifo_wr) begin
          fifo_store = expect_bit & ~buf_full;
        end else if (go_wr) begin
          if (!expect_bit) state_next = ST_EXEC_CMD;
          // A full buffer holding a truncated oversize command cannot complete; discard it.
          else if (buf_full && oversize) begin
            state_next = ST_READY;
            ptr_clear  = 1'b1;
          end
        end
      end
      ST_EXEC_CMD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) begin
          cmd_adv = 1'b1;
          if (cmd_last_o) state_next = ST_EXEC_RSP;
        end
      end
      ST_EXEC_RSP: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i) begin
          rsp_store = 1'b1;
          if (rsp_last_i || rsp_len == DEPTH_P - 1'b1) begin
            state_next = ST_COMPLETION;
            rd_clear   = 1'b1;
          end
        end
      end
      ST_COMPLETION: begin
        if (cmd_ready_wr) begin
          state_next = ST_READY;
          ptr_clear  = 1'b1;
        end else if (rd_consume && hit_fifo && active && data_avail) begin
          rd_adv = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // rd_ptr doubles as the command streaming pointer during EXEC_CMD.
  assign cmd_last_o = cmd_valid_o && (rd_ptr == wr_ptr - 1'b1);
  assign cmd_data_o = cmd_valid_o ? mem[rd_ptr[IDX_W-1:0]] : 8'h00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rsp_len  <= '0;
      cmd_size <= '0;
    end else if (ptr_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rsp_len  <= '0;
      cmd_size <= '0;
    end else begin
      if (fifo_store) begin
        wr_ptr <= wr_ptr + 1'b1;
        case (wr_ptr)
          ptr_t'(2): cmd_size[31:24] <= spi_data_i;
          ptr_t'(3): cmd_size[23:16] <= spi_data_i;
          ptr_t'(4): cmd_size[15:8]  <= spi_data_i;
          ptr_t'(5): cmd_size[7:0]   <= spi_data_i;
          default: ;
        endcase
      end
      if (rd_clear)              rd_ptr <= '0;
      else if (cmd_adv || rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (rsp_store) rsp_len <= rsp_len + 1'b1;
    end
  end

  // NOTE: the buffer has no reset so it maps onto RAM; pointers gate every read of stale data.
  always_ff @(posedge clk_i) begin
    if (fifo_store)     mem[wr_ptr[IDX_W-1:0]]  <= spi_data_i;
    else if (rsp_store) mem[rsp_len[IDX_W-1:0]] <= rsp_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active        <= 1'b0;
      offset        <= '0;
      spi_wr_done_o <= 1'b0;
      spi_rd_o      <= 1'b0;
      spi_data_o    <= '0;
    end else begin
      spi_wr_done_o <= wr_rise;
      if (wr_rise && hit_access) begin
        if (spi_data_i[ACC_ACTIVE])           active <= 1'b0;
        else if (spi_data_i[ACC_REQUEST_USE]) active <= 1'b1;
      end
      if (cs_level)                   offset <= '0;
      else if (wr_rise || rd_consume) offset <= offset + 1'b1;
      if (rd_fetch) begin
        spi_data_o <= rd_value;
        spi_rd_o   <= 1'b1;
      end else if (rd_consume) begin
        spi_rd_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tpm_tis_ctrl.sv
// Directed bench for tpm_tis_ctrl: expected read bytes and command bytes are
// queued by the stimulus and checked by a negedge monitor as the DUT presents them.
module tb_tpm_tis_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        spi_cs_i;
  logic [15:0] spi_addr_i;
  logic [7:0]  spi_data_i;
  logic        spi_wr_i;
  logic        spi_wr_done_o;
  logic        spi_req_i;
  logic [7:0]  spi_data_o;
  logic        spi_rd_o;
  logic [7:0]  cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_last_o;
  logic        cmd_ready_i;
  logic [7:0]  rsp_data_i;
  logic        rsp_valid_i;
  logic        rsp_last_i;
  logic        rsp_ready_o;

  tpm_tis_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .spi_cs_i(spi_cs_i), .spi_addr_i(spi_addr_i),
    .spi_data_i(spi_data_i), .spi_wr_i(spi_wr_i), .spi_wr_done_o(spi_wr_done_o),
    .spi_req_i(spi_req_i), .spi_data_o(spi_data_o), .spi_rd_o(spi_rd_o),
    .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_last_o(cmd_last_o),
    .cmd_ready_i(cmd_ready_i), .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i),
    .rsp_last_i(rsp_last_i), .rsp_ready_o(rsp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic last; logic [7:0] data; } cmd_beat_t;

  logic [7:0] exp_rd[$];
  string      exp_rd_tag[$];
  cmd_beat_t  exp_cmd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read bytes on spi_rd_o rising, command beats on each handshake.
  logic rd_prev = 1'b0;
  always @(negedge clk_i) begin
    if (spi_rd_o && !rd_prev) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got %0h expected no read", spi_data_o);
      end else begin
        check(exp_rd_tag.pop_front(), {24'h0, spi_data_o}, {24'h0, exp_rd.pop_front()});
      end
    end
    rd_prev = spi_rd_o;
    if (cmd_valid_o && cmd_ready_i) begin
      if (exp_cmd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL cmd_unexpected: got %0h expected no command byte", cmd_data_o);
      end else begin
        check("cmd_beat", {23'h0, cmd_last_o, cmd_data_o}, {23'h0, exp_cmd.pop_front()});
      end
    end
  end

  task automatic cs_begin(input logic [15:0] addr);
    spi_addr_i = addr;
    spi_cs_i   = 1'b0;
    repeat (3) @(posedge clk_i);
  endtask

  task automatic cs_end();
    spi_cs_i = 1'b1;
    repeat (4) @(posedge clk_i);
  endtask

  task automatic wr_byte(input logic [7:0] data);
    bit got = 0;
    spi_data_i = data;
    @(posedge clk_i); #3;
    spi_wr_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (spi_wr_done_o) begin got = 1; break; end
    end
    check("wr_done_seen", {31'h0, got}, 32'd1);
    @(negedge clk_i);
    check("wr_done_pulse", {31'h0, spi_wr_done_o}, 32'd0);
    spi_wr_i = 1'b0;
    repeat (4) @(posedge clk_i);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    bit got = 0;
    exp_rd.push_back(exp);
    exp_rd_tag.push_back(tag);
    @(posedge clk_i); #3;
    spi_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (spi_rd_o) begin got = 1; break; end
    end
    check({tag, "_fetch_seen"}, {31'h0, got}, 32'd1);
    #2 spi_req_i = 1'b0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (!spi_rd_o) begin got = 1; break; end
    end
    check({tag, "_consume_seen"}, {31'h0, got}, 32'd1);
  endtask

  task automatic reg_wr(input logic [15:0] addr, input logic [7:0] data);
    cs_begin(addr);
    wr_byte(data);
    cs_end();
  endtask

  task automatic reg_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    cs_begin(addr);
    rd_byte(tag, exp);
    cs_end();
  endtask

  task automatic sts_rd3(input string tag, input logic [7:0] b0, input logic [15:0] burst);
    cs_begin(16'h0018);
    rd_byte({tag, "_b0"}, b0);
    rd_byte({tag, "_b1"}, burst[7:0]);
    rd_byte({tag, "_b2"}, burst[15:8]);
    cs_end();
  endtask

  logic [7:0] cmd10 [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rsp4  [4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] hdr80 [6]  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h50};
  logic [7:0] hdr6  [6]  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h06};

  initial begin
    bit seen;
    rst_n_i = 1'b0; spi_cs_i = 1'b1; spi_addr_i = '0; spi_data_i = '0;
    spi_wr_i = 1'b0; spi_req_i = 1'b0; cmd_ready_i = 1'b0;
    rsp_data_i = '0; rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_wr_done", {31'h0, spi_wr_done_o}, 32'd0);
    check("rst_rd", {23'h0, spi_rd_o, spi_data_o}, 32'd0);
    check("rst_cmd", {22'h0, cmd_valid_o, cmd_last_o, cmd_data_o}, 32'd0);
    check("rst_rsp_ready", {31'h0, rsp_ready_o}, 32'd0);
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);

    // Identity registers and the unmapped / foreign-locality default.
    cs_begin(16'h0F00);
    rd_byte("did0", 8'hF4); rd_byte("did1", 8'h1A);
    rd_byte("did2", 8'h01); rd_byte("did3", 8'h00);
    rd_byte("rid", 8'h00);
    cs_end();
    reg_rd("unmapped", 16'h0100, 8'hFF);
    reg_rd("locality1", 16'h1000, 8'hFF);
    reg_rd("access_idle", 16'h0000, 8'h80);
    reg_rd("sts_idle", 16'h0018, 8'h80);
    reg_rd("fifo_inactive", 16'h0024, 8'hFF);
    reg_wr(16'h0018, 8'h40);
    sts_rd3("sts_inactive_wr", 8'h80, 16'd0);

    // Claim locality, go READY.
    reg_wr(16'h0000, 8'h02);
    reg_rd("access_active", 16'h0000, 8'hA0);
    reg_wr(16'h0018, 8'h40);
    sts_rd3("sts_ready", 8'hC0, 16'd64);

    // 10-byte command.
    for (int i = 0; i < 10; i++) begin
      reg_wr(16'h0024 + 16'(i % 4), cmd10[i]);
      if (i == 5) reg_rd("sts_after6", 16'h0018, 8'h88);
      if (i == 8) reg_rd("sts_after9", 16'h0018, 8'h88);
    end
    sts_rd3("sts_after10", 8'h80, 16'd54);

    for (int i = 0; i < 10; i++) exp_cmd.push_back({i == 9, cmd10[i]});
    cmd_ready_i = 1'b1;
    reg_wr(16'h0018, 8'h20);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (rsp_ready_o) begin seen = 1; break; end
    end
    check("exec_rsp_reached", {31'h0, seen}, 32'd1);
    check("cmd_all_sent", exp_cmd.size(), 32'd0);

    // 4-byte response.
    for (int i = 0; i < 4; i++) begin
      rsp_valid_i = 1'b1; rsp_data_i = rsp4[i]; rsp_last_i = (i == 3);
      @(negedge clk_i);
    end
    rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
    check("rsp_ready_drop", {31'h0, rsp_ready_o}, 32'd0);
    sts_rd3("sts_complete", 8'h90, 16'd4);
    cs_begin(16'h0024);
    for (int i = 0; i < 4; i++) rd_byte("fifo_rsp", rsp4[i]);
    cs_end();
    sts_rd3("sts_drained", 8'h80, 16'd0);
    reg_rd("fifo_empty1", 16'h0024, 8'hFF);
    reg_rd("fifo_empty2", 16'h0024, 8'hFF);

    // Oversize command: 65 writes with cmd_size=80.
    reg_wr(16'h0018, 8'h40);
    sts_rd3("sts_ready2", 8'hC0, 16'd64);
    for (int i = 0; i < 65; i++) reg_wr(16'h0024, (i < 6) ? hdr80[i] : 8'(i));
    sts_rd3("sts_oversize", 8'h88, 16'd0);
    reg_wr(16'h0018, 8'h20);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (cmd_valid_o) seen = 1;
    end
    check("oversize_no_exec", {31'h0, seen}, 32'd0);

    // Reset while a command is being offered to a stalled core.
    cmd_ready_i = 1'b0;
    reg_wr(16'h0018, 8'h40);
    for (int i = 0; i < 6; i++) reg_wr(16'h0024, hdr6[i]);
    reg_wr(16'h0018, 8'h20);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (cmd_valid_o) begin seen = 1; break; end
    end
    check("exec_cmd_reached", {31'h0, seen}, 32'd1);
    check("exec_cmd_first", {23'h0, cmd_last_o, cmd_data_o}, 32'h080);
    #2 rst_n_i = 1'b0;
    #1;
    check("async_rst_cmd", {22'h0, cmd_valid_o, cmd_last_o, cmd_data_o}, 32'd0);
    check("async_rst_misc", {30'h0, rsp_ready_o, spi_wr_done_o}, 32'd0);
    check("async_rst_rd", {23'h0, spi_rd_o, spi_data_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    sts_rd3("sts_after_rst", 8'h80, 16'd0);
    reg_rd("access_after_rst", 16'h0000, 8'h80);

    repeat (5) @(negedge clk_i);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("cmd_queue_drained", exp_cmd.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tpm_tis_ctrl.md
Name: tpm_tis_ctrl

Overview:
- TPM TIS register/FIFO controller that acts as the data provider behind the SPI peripheral.
- Decodes locality-0 register addresses, services byte write/read handshakes and maintains the intra-transaction byte offset.
- Owns the shared command/response buffer and runs the TIS command state machine (Idle/Ready/Reception/Execution/Completion).
- Streams complete commands to the TPM core and collects responses for host readout.

Parameters:
- BUF_DEPTH, 64, command/response buffer size in bytes (power of two, 16..256).
- DID_VID, 32'h0001_1AF4, constant returned by the TPM_DID_VID register.
- RID, 8'h00, constant returned by the TPM_RID register.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- spi_cs_i  in  1  raw SPI chip select, active low, asynchronous.
- spi_addr_i  in  16  register address of the current transaction.
- spi_data_i  in  8  write byte from the peripheral.
- spi_wr_i  in  1  write byte valid, asynchronous level.
- spi_wr_done_o  out  1  write byte consumed, 1-cycle pulse.
- spi_req_i  in  1  read request: rising edge = fetch, falling edge = consumed.
- spi_data_o  out  8  read byte.
- spi_rd_o  out  1  read byte valid.
- cmd_data_o  out  8  command byte to core.
- cmd_valid_o  out  1  command byte valid.
- cmd_last_o  out  1  last command byte.
- cmd_ready_i  in  1  core accepts command byte.
- rsp_data_i  in  8  response byte from core.
- rsp_valid_i  in  1  response byte valid.
- rsp_last_i  in  1  last response byte.
- rsp_ready_o  out  1  controller accepts response byte.

Behaviour:
- Single clock domain, async active-low reset. All outputs reset to 0. State resets to IDLE. Offset and all pointers reset to 0.
- Synchronisation: spi_cs_i, spi_wr_i and spi_req_i each pass through a 2-flop synchroniser followed by an edge detector. spi_addr_i and spi_data_i are sampled only on a detected edge; they are stable by handshake.
- Offset: byte offset = 0 while synced CS is high. It increments after each write edge and after each req falling edge. Effective address = spi_addr_i + offset, 16-bit wrap.
- Write: on a spi_wr_i rising edge, decode and apply the write, then pulse spi_wr_done_o. Latency is 3 clk from the raw rise.
- Read, fetch: on a spi_req_i rising edge, register the read value on spi_data_o and set spi_rd_o. Latency is at most 4 clk from the raw rise. clk_i must be at least 8x the SPI clock.
- Read, consume: on a spi_req_i falling edge, clear spi_rd_o, apply read side effects (FIFO pointer++) and advance the offset. spi_data_o holds until the next fetch.
- Register map, locality 0 (spi_addr_i[15:12]=0):
  - 0x0000 ACCESS: read {1'b1 regValid, 1'b0, activeLocality, 5'b0}. Write bit1 sets activeLocality; write bit5 clears it.
  - 0x0018..0x001B STS: byte0 = {stsValid=1, commandReady, tpmGo=0, dataAvail, Expect, 3'b0}. Bytes 1..2 = burstCount = BUF_DEPTH-wr_ptr in Reception/Ready, remaining response bytes in Completion, else 0. Byte 3 = 0.
  - 0x0024..0x0027 DATA_FIFO: all four addresses alias the FIFO.
  - 0x0F00..0x0F03 DID_VID, little-endian. 0x0F04 RID.
- Unmapped addresses and other localities: reads return 0xFF; writes are ignored.
- Any register write or FIFO access while activeLocality=0 is ignored, except ACCESS. FIFO reads in that case return 0xFF.
- State machine:
  - IDLE: STS write commandReady=1 -> READY, wr_ptr=0.
  - READY: first FIFO write -> RECEPTION.
  - RECEPTION: FIFO write stores byte at wr_ptr, wr_ptr++. Bytes 2..5 form a big-endian cmd_size. Expect=1 until wr_ptr==cmd_size (with wr_ptr>=6). STS tpmGo write with Expect=0 -> EXEC_CMD.
  - EXEC_CMD: stream buf[0..cmd_size-1] with a valid/ready handshake. cmd_last_o is set on the final byte. Transfer of the last byte -> EXEC_RSP.
  - EXEC_RSP: rsp_ready_o=1. Store bytes, rsp_len++. rsp_last_i or buffer full -> COMPLETION, rd_ptr=0.
  - COMPLETION: dataAvail=1 while rd_ptr<rsp_len. FIFO reads return buf[rd_ptr].
- From READY, RECEPTION or COMPLETION, a commandReady write -> READY with pointers cleared. In EXEC_* it is ignored.
- Boundaries:
  - FIFO write when wr_ptr==BUF_DEPTH or Expect=0: byte dropped.
  - FIFO read when rd_ptr==rsp_len: returns 0xFF and rd_ptr holds.
  - tpmGo with Expect=1: ignored.
  - cmd_size > BUF_DEPTH: Expect stays 1 until the buffer is full, then the command is dropped on tpmGo.
  - Simultaneous write edge and req edge cannot occur by protocol. If it happens, the write wins.
  - CS rising mid-transfer resets the offset only; state is unaffected.

Decomposition:
- Package tpm_tis_pkg:
  - State enum.
  - Register offset constants (ACCESS, STS, DATA_FIFO, DID_VID, RID).
  - STS/ACCESS bit positions.
- Sub-module sync_edge: 2-flop synchroniser with rise/fall pulse outputs, instantiated three times.
- The buffer is inferred RAM inside the controller.

Test Plan:
- Reset, then read DID_VID at 0x0F00 over a 4-byte burst -> bytes F4,1A,01,00. Read ACCESS -> 0x80.
- Write ACCESS=0x02, write STS byte0=0x40, read STS -> 0xC0 with burstCount=64.
- Write FIFO with 10-byte command (size field 0x0000000A). Expect stays 1 through byte 9, 0 after byte 10. tpmGo -> core receives 10 bytes, cmd_last_o on the 10th.
- Core returns 4 bytes AA,BB,CC,DD with rsp_last_i -> STS dataAvail=1, burstCount=4. FIFO reads return AA..DD, then dataAvail=0 and the next read returns 0xFF.
- Write 65 bytes with cmd_size=80 -> byte 65 dropped, Expect=1, tpmGo ignored.
- Assert rst_n_i low during EXEC_CMD -> all outputs 0 immediately, state IDLE, STS byte0 reads 0x80.
